// File: rtl/adc_sample_ctrl.sv
// ADC sweep sequencer: settles each masked channel, averages 2^AVG_LOG2 conversions,
// and reports one result per channel; a missing adcrdy sets a sticky timeout flag.
//
// state  | meaning
// IDLE   | ADC off, waiting for enable with a non-empty mask
// SETTLE | channel mux settling, SETTLE_CYC cycles
// REQ    | one-cycle conversion request
// WAIT   | waiting for adcrdy, bounded by TIMEOUT_CYC
// OUT    | one-cycle result strobe
// NEXT   | choose next channel or return to IDLE
module adc_sample_ctrl #(
    parameter int SETTLE_CYC  = 16,
    parameter int TIMEOUT_CYC = 4096,
    parameter int AVG_LOG2    = 2
) (
    input  logic        clk,
    input  logic        drstn,
    input  logic        enable,
    input  logic [7:0]  ch_mask,
    output logic        adcen,
    output logic [2:0]  vsenctl,
    output logic        adcreqi,
    input  logic        adcrdy,
    input  logic [13:0] adcvalue,
    output logic        result_valid,
    output logic [2:0]  result_ch,
    output logic [13:0] result_data,
    output logic        busy,
    output logic        timeout_err,
    input  logic        err_clr
);

    localparam int         ACC_W = 14 + AVG_LOG2;
    localparam logic [4:0] N_SMP = 5'(1 << AVG_LOG2);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETTLE,
        S_REQ,
        S_WAIT,
        S_NEXT,
        S_OUT
    } state_t;

    state_t           state, state_nxt;
    logic [7:0]       settle_cnt;
    logic [15:0]      to_cnt;
    logic [4:0]       smp_cnt;
    logic [ACC_W-1:0] acc, acc_sum, avg;
    logic [2:0]       ch_low, ch_next, ch_load;
    logic             found_low, found_up;
    logic             capture, timeout, start_ch, last_smp;

    // Lowest set bit, and the next set bit strictly above the current channel (wrapping).
    always_comb begin
        ch_low    = '0;
        ch_next   = '0;
        found_low = 1'b0;
        found_up  = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (ch_mask[i] && !found_low) begin
                ch_low    = 3'(i);
                found_low = 1'b1;
            end
            if (ch_mask[i] && !found_up && (3'(i) > vsenctl)) begin
                ch_next  = 3'(i);
                found_up = 1'b1;
            end
        end
        if (!found_up)
            ch_next = ch_low;
    end

    assign ch_load  = (state == S_IDLE) ? ch_low : ch_next;
    assign acc_sum  = acc + ACC_W'(adcvalue);
    assign avg      = acc_sum >> AVG_LOG2;
    assign last_smp = (smp_cnt + 5'd1) >= N_SMP;

    always_ff @(posedge clk or negedge drstn) begin
        if (!drstn)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        capture   = 1'b0;
        timeout   = 1'b0;
        start_ch  = 1'b0;
        case (state)
            S_IDLE: begin
                if (enable && (ch_mask != 8'd0)) begin
                    state_nxt = S_SETTLE;
                    start_ch  = 1'b1;
                end
            end
            S_SETTLE: begin
                if (settle_cnt == 8'd0)
                    state_nxt = S_REQ;
            end
            S_REQ: state_nxt = S_WAIT;
            S_WAIT: begin
                if (adcrdy) begin
                    capture   = 1'b1;
                    state_nxt = last_smp ? S_OUT : S_REQ;
                end else if (to_cnt == 16'd0) begin
                    timeout   = 1'b1;
                    state_nxt = S_NEXT;
                end
            end
            S_OUT: state_nxt = S_NEXT;
            S_NEXT: begin
                if (enable && (ch_mask != 8'd0)) begin
                    state_nxt = S_SETTLE;
                    start_ch  = 1'b1;
                end else begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    assign adcen        = (state != S_IDLE);
    assign busy         = (state != S_IDLE);
    assign adcreqi      = (state == S_REQ);
    assign result_valid = (state == S_OUT);

    always_ff @(posedge clk or negedge drstn) begin
        if (!drstn) begin
            vsenctl    <= '0;
            settle_cnt <= '0;
            acc        <= '0;
            smp_cnt    <= '0;
        end else if (start_ch) begin
            vsenctl    <= ch_load;
            settle_cnt <= 8'(SETTLE_CYC - 1);
            acc        <= '0;
            smp_cnt    <= '0;
        end else begin
            if ((state == S_SETTLE) && (settle_cnt != 8'd0))
                settle_cnt <= settle_cnt - 8'd1;
            if (capture) begin
                acc     <= acc_sum;
                smp_cnt <= smp_cnt + 5'd1;
            end else if (timeout) begin
                acc     <= '0;
                smp_cnt <= '0;
            end
        end
    end

    // Timeout down-counter is reloaded in REQ so every conversion gets the full window.
    always_ff @(posedge clk or negedge drstn) begin
        if (!drstn)
            to_cnt <= '0;
        else if (state == S_REQ)
            to_cnt <= 16'(TIMEOUT_CYC - 1);
        else if ((state == S_WAIT) && !adcrdy && (to_cnt != 16'd0))
            to_cnt <= to_cnt - 16'd1;
    end

    always_ff @(posedge clk or negedge drstn) begin
        if (!drstn) begin
            result_data <= '0;
            result_ch   <= '0;
        end else if (capture && last_smp) begin
            result_data <= avg[13:0];
            result_ch   <= vsenctl;
        end
    end

    always_ff @(posedge clk or negedge drstn) begin
        if (!drstn)
            timeout_err <= 1'b0;
        else if (timeout)
            timeout_err <= 1'b1;
        else if (err_clr)
            timeout_err <= 1'b0;
    end

endmodule
